// File: rtl/rfg_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : rfg_register_bank
//  Purpose  : Byte-wide register bank with eight control registers, an ID
//             constant, a 32-bit transaction counter with a read snapshot,
//             a readout FIFO with level/status reporting, and a one-cycle
//             registered read response path.
//  Revision : 1.0  initial release
// ============================================================================
module rfg_register_bank #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] rfg_address,
    input  logic [7:0]  rfg_write_value,
    input  logic        rfg_write,
    input  logic        rfg_write_last,
    input  logic        rfg_read,
    output logic        rfg_read_valid,
    output logic [7:0]  rfg_read_value,
    output logic [63:0] ctrl_regs,
    input  logic [7:0]  fifo_wdata,
    input  logic        fifo_wvalid,
    output logic        fifo_wready
);

    localparam int unsigned  c_aw         = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(FIFO_DEPTH);

    logic [7:0]      r_ctrl [0:7];
    logic [31:0]     r_counter;
    logic [31:0]     r_snapshot;
    logic [7:0]      r_mem [0:FIFO_DEPTH-1];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic            r_overflow;
    logic            r_underflow;
    logic            r_ready_en;
    logic            r_read_valid;
    logic [7:0]      r_read_value;

    logic            w_is_ctrl;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_fifo_rd;
    logic            w_pop;
    logic            w_status_wr;
    logic            w_ovf_set;
    logic            w_unf_set;
    logic [7:0]      w_rdata;

    assign w_is_ctrl   = (rfg_address[15:3] == 13'd0);
    assign w_full      = (r_level == c_full_level);
    assign w_empty     = (r_level == '0);
    // The push handshake is held off during reset and the cycle it releases.
    assign fifo_wready = r_ready_en && !w_full;
    assign w_push      = fifo_wvalid && fifo_wready;
    assign w_fifo_rd   = rfg_read && (rfg_address == 16'h0010);
    assign w_pop       = w_fifo_rd && !w_empty;
    assign w_status_wr = rfg_write && (rfg_address == 16'h0012);
    assign w_ovf_set   = fifo_wvalid && w_full;
    assign w_unf_set   = w_fifo_rd && w_empty;

    assign rfg_read_valid = r_read_valid;
    assign rfg_read_value = r_read_value;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_ctrl_out
            assign ctrl_regs[8*i +: 8] = r_ctrl[i];
        end
    endgenerate

    // Control registers: byte-addressed writes into 0x0000..0x0007.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 8; i++) r_ctrl[i] <= 8'h00;
        end else if (rfg_write && w_is_ctrl) begin
            r_ctrl[rfg_address[2:0]] <= rfg_write_value;
        end
    end

    // Transaction counter (clear on write to 0x0009 beats increment) and snapshot.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_counter  <= 32'd0;
            r_snapshot <= 32'd0;
        end else begin
            if (rfg_write && (rfg_address == 16'h0009))
                r_counter <= 32'd0;
            else if (rfg_write && rfg_write_last)
                r_counter <= r_counter + 32'd1;
            if (rfg_read && (rfg_address == 16'h0009))
                r_snapshot <= r_counter;
        end
    end

    // FIFO storage; contents need no reset because the level gates all reads.
    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= fifo_wdata;
    end

    // FIFO pointers, level and the push-enable that rises after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky status flags, write-1-to-clear; a same-cycle set takes priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !(w_status_wr && rfg_write_value[0])) || w_ovf_set;
            r_underflow <= (r_underflow && !(w_status_wr && rfg_write_value[1])) || w_unf_set;
        end
    end

    // Read data mux over pre-update state, so same-cycle writes are not visible.
    always_comb begin
        w_rdata = 8'h00;
        if (w_is_ctrl) begin
            w_rdata = r_ctrl[rfg_address[2:0]];
        end else begin
            case (rfg_address)
                16'h0008: w_rdata = ID_VALUE;
                16'h0009: w_rdata = r_counter[7:0];
                16'h000A: w_rdata = r_snapshot[15:8];
                16'h000B: w_rdata = r_snapshot[23:16];
                16'h000C: w_rdata = r_snapshot[31:24];
                16'h0010: w_rdata = w_empty ? 8'h00 : r_mem[r_rd_ptr];
                16'h0011: w_rdata = 8'(r_level);
                16'h0012: w_rdata = {6'd0, r_underflow, r_overflow};
                default:  w_rdata = 8'h00;
            endcase
        end
    end

    // One-cycle registered read response, one byte per read strobe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_read_valid <= 1'b0;
            r_read_value <= 8'h00;
        end else begin
            r_read_valid <= rfg_read;
            r_read_value <= rfg_read ? w_rdata : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: doc/rfg_register_bank.md
RFG_REGISTER_BANK -- requirements
Module: rfg_register_bank

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, readout FIFO depth in bytes; must be a power of two, minimum 4.
REQ-002 Parameter ID_VALUE, default 8'hA5, constant returned at address 0x0008.
REQ-003 One clock and one reset; reset is asynchronous and active-low.
REQ-004 aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 rfg_address  in  16  register byte address.
REQ-007 rfg_write_value  in  8  write data.
REQ-008 rfg_write  in  1  write strobe, one byte per high cycle.
REQ-009 rfg_write_last  in  1  marks the final byte of a write transaction.
REQ-010 rfg_read  in  1  read strobe, one byte per high cycle.
REQ-011 rfg_read_valid  out  1  read data qualifier.
REQ-012 rfg_read_value  out  8  read data.
REQ-013 ctrl_regs  out  64  control bytes 0x0000..0x0007; byte n drives bits [8n+7:8n].
REQ-014 fifo_wdata  in  8  readout FIFO push data.
REQ-015 fifo_wvalid  in  1  push request.
REQ-016 fifo_wready  out  1  high when the FIFO is not full.

Function
REQ-017 Address map:
- 0x0000..0x0007: control R/W.
- 0x0008: ID, read-only.
- 0x0009..0x000C: transaction counter snapshot, little-endian.
- 0x0010: FIFO data, pop on read.
- 0x0011: FIFO level.
- 0x0012: status; bit0 overflow, bit1 underflow, write-1-to-clear.
REQ-018 A write lands at the clock edge where rfg_write is high; writes to read-only or unmapped addresses are ignored.
REQ-019 Each rfg_read cycle produces exactly one rfg_read_valid pulse on the next cycle, carrying that address's data.
REQ-020 Reads may occur on every cycle, giving one output byte per cycle with no bubbles.
REQ-021 rfg_read_valid is low in every cycle not preceded by an rfg_read cycle.
REQ-022 Unmapped reads return 8'h00.
REQ-023 Read and write to the same address in the same cycle: the read returns the pre-write value.
REQ-024 Transaction counter: 32 bits; increments by 1 on each cycle with rfg_write && rfg_write_last; wraps from 0xFFFFFFFF to 0.
REQ-025 Reading 0x0009 returns counter bits [7:0] and loads the full 32-bit counter value into the snapshot register in the same cycle.
REQ-026 Reads of 0x000A..0x000C return snapshot bytes 1..3.
REQ-027 Any write to 0x0009 clears the counter. If an increment coincides with the clear, the clear wins and the increment is lost.
REQ-028 FIFO push occurs when fifo_wvalid && fifo_wready.
REQ-029 fifo_wvalid while full drops the byte and sets the overflow flag.
REQ-030 FIFO pop occurs on a read of 0x0010 while not empty; the read returns the head byte.
REQ-031 Read of 0x0010 while empty returns 8'h00, pops nothing and sets the underflow flag.
REQ-032 Simultaneous push and pop leave the level unchanged; the level counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-033 A push into an empty FIFO is readable on the following cycle.
REQ-034 Read of 0x0011 returns the level, zero-extended or truncated to 8 bits, sampled before any same-cycle push or pop.
REQ-035 A status flag set and a write-1-clear of that flag in the same cycle: the set wins.

Reset
REQ-036 While aresetn is low, the following are zero: ctrl_regs, rfg_read_valid, rfg_read_value, counter, snapshot, FIFO level and pointers, both flags.
REQ-037 While aresetn is low, fifo_wready is low.
REQ-038 fifo_wready rises in the first cycle after reset release.
REQ-039 Reset asserted mid-transaction discards FIFO contents and any pending read response; no rfg_read_valid is emitted after reset asserts.

Verification
REQ-040 Write 0x5A to 0x0003 with rfg_write_last, then read 0x0003 -> rfg_read_valid one cycle after the read, value 0x5A; ctrl_regs[31:24]=0x5A; counter=1.
REQ-041 Read 0x0008, 0x0000 and 0x00FF back-to-back on three cycles -> three consecutive valid bytes A5, 00, 00.
REQ-042 Push 0x11, 0x22, 0x33; read 0x0011, then 0x0010 four times -> values 03, 11, 22, 33, 00; status reads 0x02.
REQ-043 Push 17 bytes with FIFO_DEPTH=16 -> fifo_wready low after 16 pushes; status bit0 set; writing 0x01 to 0x0012 clears it.
REQ-044 Preload counter to 0xFFFFFFFF via 2^32 increments or a bench-forced value, then one write_last -> counter 0; read 0x0009..0x000C returns 00 00 00 00.
REQ-045 Assert aresetn low during a 4-byte FIFO burst read -> no further rfg_read_valid; after release, level reads 0 and ctrl_regs=0.
